// File: rtl/addsub_seq16_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_seq16_pkg;

    // Width of one arithmetic slice processed per RUN cycle.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/addsub_seq16_nibble.sv
// 4-bit ripple slice, plus the 1-bit full adder it is built from.
// Latency: purely combinational.
// Backpressure: none.
//
// full_adder_1bit ports:
//   a, b, cin : input bits
//   s, cout   : sum bit and carry-out
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// nibble_addsub ports:
//   a, b  : 4-bit slice operands (b already inverted by the caller for subtract)
//   cin   : carry into bit 0
//   s     : 4-bit slice sum
//   c3    : carry into bit 3, used with cout to detect signed overflow
//   cout  : carry out of bit 3
module nibble_addsub
    import addsub_seq16_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               c3,
    output logic               cout
);
    // c[k] is the carry into bit k; c[SLICE_W] is the slice carry-out.
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar k = 0; k < SLICE_W; k++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (a[k]),
            .b    (b[k]),
            .cin  (c[k]),
            .s    (s[k]),
            .cout (c[k+1])
        );
    end

    assign c3   = c[SLICE_W-1];
    assign cout = c[SLICE_W];
endmodule

// File: rtl/addsub_seq16.sv
// Nibble-serial two's complement add/subtract: one 4-bit slice per cycle.
// Latency: start accepted at edge t -> done high in the cycle after edge t+NIBBLES.
// Backpressure: start is ignored while busy; a new start is accepted in IDLE or DONE.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start, sub  : begin an operation; sub=1 selects A-B, sub=0 selects A+B
//   A, B        : W-bit operands, latched with an accepted start
//   busy, done  : high in RUN / one-cycle pulse in DONE
//   Sum, Ovfl   : result register and signed-overflow flag, held until next start
module addsub_seq16
    import addsub_seq16_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Sum,
    output logic         Ovfl
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          sub_q;
    // Operands shift right one slice per RUN cycle so the active slice is
    // always in the low nibble; no W-bit adder is ever formed.
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c3;
    logic               sl_cout;

    // Subtract is A + ~B + 1: B is inverted here and the +1 comes from the
    // carry register being preset to sub on start.
    assign sl_a = a_sh[SLICE_W-1:0];
    assign sl_b = b_sh[SLICE_W-1:0] ^ {SLICE_W{sub_q}};

    nibble_addsub u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .c3   (sl_c3),
        .cout (sl_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Ovfl  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        sub_q <= sub;
                        carry <= sub;
                        idx   <= '0;
                        Sum   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    Sum[idx*SLICE_W +: SLICE_W] <= sl_s;
                    carry <= sl_cout;
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Signed overflow: carry into the sign bit differs
                        // from carry out of it.
                        Ovfl  <= sl_c3 ^ sl_cout;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq16.sv
// Self-checking bench for addsub_seq16 with a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_addsub_seq16;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Ovfl;

    always #5 clk = ~clk;

    addsub_seq16 #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Ovfl  (Ovfl)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: phase 0 = idle, 1..N = slices already written is
    // phase-1, N+1 = result presented.
    int           m_phase = 0;
    logic [W-1:0] m_res   = '0;
    logic         m_rov   = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_ovfl  = 1'b0;

    function automatic logic [W:0] ref_op(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
        logic [W-1:0] r;
        logic         ov;
        if (s) begin
            r  = a - b;
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r  = a + b;
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ov, r};
    endfunction

    function automatic logic [W-1:0] low_bits(input logic [W-1:0] v, input int nbits);
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < W; k++)
            if (k < nbits) m[k] = 1'b1;
        return v & m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = '0;
            m_ovfl  = 1'b0;
        end else if (m_phase == 0 || m_phase == N + 1) begin
            if (start) begin
                {m_rov, m_res} = ref_op(A, B, sub);
                m_sum   = '0;
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end else begin
            m_phase = m_phase + 1;
            m_sum   = low_bits(m_res, 4 * (m_phase - 1));
            if (m_phase == N + 1) m_ovfl = m_rov;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= N));
            check("done", 32'(done), 32'(m_phase == N + 1));
            check("sum",  32'(Sum),  32'(m_sum));
            check("ovfl", 32'(Ovfl), 32'(m_ovfl));
        end
        if (done === 1'b1) done_cnt++;
    end

    // Waits at negedges for done; returns the number of negedges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 30);
        if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic eo);
        int cyc;
        start = 1'b1; A = a; B = b; sub = s;
        @(negedge clk);
        start = 1'b0; A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"},  32'(cyc),  32'd5);
        check({name, "_sum"},  32'(Sum),  32'(es));
        check({name, "_ovfl"}, 32'(Ovfl), 32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int dc0;
        logic abort;

        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(Sum),  32'd0);
        check("rst_ovfl", 32'(Ovfl), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
        run_op("sub_min", 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
        run_op("add_neg", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start during RUN must be ignored.
        dc0 = done_cnt;
        start = 1'b1; A = 16'h1234; B = 16'h1111; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 16'hFFFF; B = 16'h0F0F; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ign_sum",  32'(Sum),  32'h2345);
        check("ign_ovfl", 32'(Ovfl), 32'd0);
        repeat (8) @(negedge clk);
        check("ign_done_count", 32'(done_cnt - dc0), 32'd1);

        // Reset in the third RUN cycle aborts with no done.
        start = 1'b1; A = 16'h00FF; B = 16'h0001; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(Sum),  32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

        // start held high: back-to-back acceptance from DONE.
        start = 1'b1; A = 16'h0001; B = 16'h0001; sub = 1'b0;
        wait_done(cyc);
        check("b2b_sum1", 32'(Sum), 32'h0002);
        A = 16'h0003; B = 16'h0001; sub = 1'b1;
        @(negedge clk);
        check("b2b_done_fall", 32'(done), 32'd0);
        check("b2b_busy_rise", 32'(busy), 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_gap",  32'(cyc), 32'd5);
        check("b2b_sum2", 32'(Sum), 32'h0002);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_hold_sum",  32'(Sum),  32'h0002);

        // Randomized operations with junk inputs while busy and occasional aborts.
        repeat (80) begin
            repeat ($urandom_range(0, 3)) begin
                A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
                @(negedge clk);
            end
            start = 1'b1; A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
            abort = ($urandom_range(0, 7) == 0);
            if (abort) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                cyc = 1;
                while (done !== 1'b1 && cyc < 30) begin
                    start = 1'($urandom); A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
                    @(negedge clk);
                    cyc++;
                end
                start = 1'b0;
                check("rnd_lat", 32'(cyc), 32'd5);
            end
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
